// File: rtl/fsm_key_multi.sv
// -----------------------------------------------------------------------------
// fsm_key_multi
//   Multi-key debouncer with one independent FSM per key. Each raw key input is
//   brought into the clock domain through a 2-FF synchroniser and then
//   debounced. The block emits a debounced level, one-cycle press and release
//   pulses, a long-press pulse once per hold, and periodic auto-repeat pulses.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   key_in       in   KEY_W  raw asynchronous key inputs
//   key_state    out  KEY_W  debounced level, 1 = pressed
//   key_press    out  KEY_W  1-cycle pulse on debounced press
//   key_release  out  KEY_W  1-cycle pulse on debounced release
//   key_long     out  KEY_W  1-cycle pulse, TIME_LONG held cycles after press
//   key_repeat   out  KEY_W  1-cycle pulse every TIME_REPEAT held cycles after key_long
// -----------------------------------------------------------------------------
module fsm_key_multi #(
  parameter int KEY_W       = 3,
  parameter int TIME_20MS   = 1_000_000,
  parameter int TIME_LONG   = 50_000_000,
  parameter int TIME_REPEAT = 10_000_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  localparam int DB_W     = $clog2(TIME_20MS);
  localparam int HOLD_MAX = (TIME_LONG > TIME_REPEAT) ? TIME_LONG : TIME_REPEAT;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(TIME_20MS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(TIME_LONG - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(TIME_REPEAT - 1);
  localparam bit                REPEAT_EN = (TIME_REPEAT != 0);

  // Raw level that means "released"; the synchroniser resets to it so that a
  // reset never looks like a key edge.
  localparam logic [KEY_W-1:0] REL_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [KEY_W-1:0] sync1_q, sync2_q;
  logic [KEY_W-1:0] pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= REL_LEVEL;
      sync2_q <= REL_LEVEL;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // pre-edge values and the two synchroniser stages really are two stages.
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Polarity-normalised pressed flag: 1 = pressed, whatever ACTIVE_LOW says.
  assign pressed = sync2_q ^ REL_LEVEL;

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    logic [1:0]        st_q, st_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              state_q, state_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              p;

    assign p = pressed[k];

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      st_d        = st_q;
      db_d        = db_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      state_d     = state_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      unique case (st_q)
        ST_IDLE: begin
          if (p) begin
            st_d = ST_PRESS_DB;
            db_d = '0;
          end
        end
        ST_PRESS_DB: begin
          if (!p) begin
            st_d = ST_IDLE;                   // glitch rejected silently
          end else if (db_q == DB_LAST) begin
            st_d        = ST_HOLD;
            press_d     = 1'b1;
            state_d     = 1'b1;
            hold_d      = '0;
            long_done_d = 1'b0;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
        default: begin                        // ST_HOLD, ST_REL_DB
          if (!p && st_q == ST_HOLD) begin
            st_d = ST_REL_DB;                 // hold_cnt frozen from here
            db_d = '0;
          end else if (!p) begin
            if (db_q == DB_LAST) begin
              st_d      = ST_IDLE;
              release_d = 1'b1;
              state_d   = 1'b0;
            end else begin
              db_d = db_q + DB_W'(1);
            end
          end else begin
            // Key seen pressed: count this cycle as held time. Returning from
            // REL_DB counts too, so a glitch of N cycles delays long/repeat by
            // exactly N cycles.
            st_d = ST_HOLD;
            if (!long_done_q && hold_q == LONG_LAST) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
              hold_d      = '0;
            end else if (long_done_q && REPEAT_EN && hold_q == REP_LAST) begin
              repeat_d = 1'b1;
              hold_d   = '0;
            end else if (!long_done_q || REPEAT_EN) begin
              // With repeat disabled the counter parks after key_long, so it
              // can never wrap during an arbitrarily long hold.
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q        <= ST_IDLE;
        db_q        <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        state_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        st_q        <= st_d;
        db_q        <= db_d;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
        state_q     <= state_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    assign key_state[k]   = state_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
    assign key_repeat[k]  = repeat_q;
  end

endmodule

// File: tb/tb_fsm_key_multi.sv
// -----------------------------------------------------------------------------
// tb_fsm_key_multi
//   Self-checking bench for fsm_key_multi (3 keys, 50-cycle debounce, 200-cycle
//   long press, 40-cycle repeat, active-low keys). A behavioural model expresses
//   debouncing as "TIME_20MS+1 consecutive samples disagreeing with the debounced
//   level" and hold timing as "count of pressed samples while debounced-pressed";
//   the compare process checks every cycle against it. Directed scenarios add
//   hand-computed literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fsm_key_multi;

  localparam int KW    = 3;
  localparam int T20   = 50;
  localparam int TLONG = 200;
  localparam int TREP  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KW-1:0] key_in = '1;
  logic [KW-1:0] key_state, key_press, key_release, key_long, key_repeat;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  fsm_key_multi #(
    .KEY_W(KW), .TIME_20MS(T20), .TIME_LONG(TLONG),
    .TIME_REPEAT(TREP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_s1 [KW];
  bit       m_s2 [KW];
  bit       m_lvl[KW];
  int       m_run[KW];
  int       m_held[KW];
  bit       m_ldone[KW];
  logic [KW-1:0] e_state = '0, e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;

  task automatic model_step();
    bit p;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int k = 0; k < KW; k++) begin
      if (rst) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1;
        m_lvl[k] = 1'b0; m_run[k] = 0; m_held[k] = 0; m_ldone[k] = 1'b0;
      end else begin
        p = !m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = key_in[k];
        if (p != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == T20 + 1) begin
            m_lvl[k] = p;
            m_run[k] = 0;
            m_held[k] = 0;
            m_ldone[k] = 1'b0;
            if (p) e_press[k] = 1'b1;
            else   e_rel[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
          if (m_lvl[k]) begin
            m_held[k]++;
            if (!m_ldone[k] && m_held[k] == TLONG) begin
              e_long[k] = 1'b1; m_ldone[k] = 1'b1; m_held[k] = 0;
            end else if (m_ldone[k] && TREP != 0 && m_held[k] == TREP) begin
              e_rep[k] = 1'b1; m_held[k] = 0;
            end
          end
        end
      end
      e_state[k] = m_lvl[k];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    if (rst) cmp_en = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en)
      check("outputs_vs_model",
            {17'd0, key_state, key_press, key_release, key_long, key_repeat},
            {17'd0, e_state, e_press, e_rel, e_long, e_rep});
  end

  // ---------------- stimulus ----------------
  int cd[KW];
  int npress;

  initial begin
    // 1: reset with keys released
    rst = 1'b1; key_in = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_outputs_zero", {key_state, key_press, key_release, key_long, key_repeat}, 0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10)
        check("idle_outputs_zero", {key_state, key_press, key_release, key_long, key_repeat}, 0);
    end

    // 2: key 1 pressed for 100 cycles
    key_in = 3'b101;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 52) check("t2_press_early", key_press, 3'b000);
      if (i == 53) check("t2_press_pulse", key_press, 3'b010);
      if (i == 54) check("t2_press_one_cycle", key_press, 3'b000);
      if (i == 100) check("t2_state_held", key_state, 3'b010);
    end

    // 3: release
    key_in = 3'b111;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 52) check("t3_release_early", key_release, 3'b000);
      if (i == 53) check("t3_release_pulse", key_release, 3'b010);
      if (i == 54) check("t3_state_released", key_state, 3'b000);
    end

    // 4: bouncing key 0, never stable long enough
    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) key_in[0] = ~key_in[0];
      @(negedge clk);
    end
    key_in = 3'b111;
    repeat (60) @(negedge clk);
    check("t4_bounce_state", key_state, 3'b000);

    // 5: keys 0 and 2 together, held 400 cycles
    key_in = 3'b010;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 52)  check("t5_press_early", key_press, 3'b000);
      if (i == 53)  check("t5_press_pulse", key_press, 3'b101);
      if (i == 252) check("t5_long_early", key_long, 3'b000);
      if (i == 253) check("t5_long_pulse", key_long, 3'b101);
      if (i == 292) check("t5_repeat_early", key_repeat, 3'b000);
      if (i == 293) check("t5_repeat1", key_repeat, 3'b101);
      if (i == 333) check("t5_repeat2", key_repeat, 3'b101);
      if (i == 373) check("t5_repeat3", key_repeat, 3'b101);
    end
    key_in = 3'b111;
    repeat (80) @(negedge clk);

    // 6a: 20-cycle release glitch during hold delays key_long by 20
    key_in = 3'b101;
    repeat (53) @(negedge clk);
    check("t6_press_pulse", key_press, 3'b010);
    repeat (50) @(negedge clk);
    key_in = 3'b111;
    repeat (20) @(negedge clk);
    key_in = 3'b101;
    repeat (149) @(negedge clk);
    check("t6_long_not_yet", key_long, 3'b000);
    @(negedge clk);
    check("t6_long_delayed", key_long, 3'b010);
    check("t6_state_kept", key_state, 3'b010);
    key_in = 3'b111;
    repeat (80) @(negedge clk);

    // 6b: reset while in PRESS_DB, key still held -> fresh press after reset
    key_in = 3'b101;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_outputs_zero", {key_state, key_press, key_release, key_long, key_repeat}, 0);
    rst = 1'b0;
    npress = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 53) check("t6_fresh_press", key_press, 3'b010);
      else if (key_press != 3'b000) npress++;
    end
    check("t6_no_stray_press", npress, 0);
    key_in = 3'b111;
    repeat (80) @(negedge clk);

    // randomized phase: mixed glitches and long holds, rare resets
    for (int k = 0; k < KW; k++) cd[k] = $urandom_range(1, 100);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      for (int k = 0; k < KW; k++) begin
        if (cd[k] == 0) begin
          key_in[k] = ~key_in[k];
          cd[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 45) : $urandom_range(45, 450);
        end else begin
          cd[k]--;
        end
      end
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 1'b0;
    key_in = 3'b111;
    repeat (70) @(negedge clk);
    check("final_released", key_state, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
